// File: rtl/mix_columns.sv
// rtl/mix_columns.sv - iterative AES MixColumns, one column per cycle, with final-round bypass
module mix_columns #(
    parameter int WORD = 32,
    parameter int NB   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_valid,
    input  logic [WORD*NB-1:0] i_block,
    input  logic               i_last,
    output logic               o_ready,
    output logic               o_valid,
    output logic [WORD*NB-1:0] o_block,
    output logic               o_last,
    input  logic               i_ready,
    output logic               o_overrun
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         col_q, col_d;
    logic [WORD*NB-1:0] blk_q, blk_d;
    logic               last_q, last_d;
    logic               overrun_q, overrun_d;
    logic               accept;
    logic [WORD-1:0]    cur_col;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        mix_col[31:24] = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
        mix_col[23:16] = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
        mix_col[15:8]  = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
        mix_col[7:0]   = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
    endfunction

    assign accept = i_valid && o_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            col_q     <= 2'd0;
            blk_q     <= '0;
            last_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            blk_q     <= blk_d;
            last_q    <= last_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = i_last ? DONE : BUSY;
            end
            BUSY: begin
                if (col_q == 2'd3) state_d = DONE;
            end
            DONE: begin
                // Consume and accept on the same edge keeps back-to-back blocks bubble-free
                if (accept)       state_d = i_last ? DONE : BUSY;
                else if (i_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cur_col   = blk_q[(NB-1-int'(col_q))*WORD +: WORD];
        blk_d     = blk_q;
        col_d     = col_q;
        last_d    = last_q;
        overrun_d = overrun_q | (i_valid && !o_ready);
        if (accept) begin
            blk_d  = i_block;
            last_d = i_last;
            col_d  = 2'd0;
        end else if (state_q == BUSY) begin
            blk_d[(NB-1-int'(col_q))*WORD +: WORD] = mix_col(cur_col);
            col_d = col_q + 2'd1;
        end
    end

    always_comb begin
        o_ready   = rst && (state_q == IDLE || (state_q == DONE && i_ready));
        o_valid   = (state_q == DONE);
        o_block   = blk_q;
        o_last    = last_q;
        o_overrun = overrun_q;
    end

endmodule

// File: tb/tb_mix_columns.sv
// tb/tb_mix_columns.sv - self-checking bench for mix_columns against a GF(2^8) matrix model
module tb_mix_columns;

    logic         clk;
    logic         rst;
    logic         i_valid;
    logic [127:0] i_block;
    logic         i_last;
    logic         o_ready;
    logic         o_valid;
    logic [127:0] o_block;
    logic         o_last;
    logic         i_ready;
    logic         o_overrun;

    int total = 0;
    int bad   = 0;

    mix_columns #(.WORD(32), .NB(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (i_valid),
        .i_block   (i_block),
        .i_last    (i_last),
        .o_ready   (o_ready),
        .o_valid   (o_valid),
        .o_block   (o_block),
        .o_last    (o_last),
        .i_ready   (i_ready),
        .o_overrun (o_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] blk;
        logic         last;
        logic [127:0] exp;
    } vec_t;

    // Generic shift-and-add multiply in GF(2^8) with the AES polynomial
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic       hi;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            hi = x[7];
            x  = {x[6:0], 1'b0};
            if (hi) x = x ^ 8'h1b;
        end
        return p;
    endfunction

    // MixColumns matrix is circulant: row r is (2,3,1,1) rotated right by r
    function automatic logic [7:0] coef(input int r, input int k);
        int d;
        d = (k - r + 4) % 4;
        if (d == 0) return 8'h02;
        if (d == 1) return 8'h03;
        return 8'h01;
    endfunction

    function automatic logic [127:0] ref_model(input logic [127:0] blk, input logic last);
        logic [127:0] res;
        logic [7:0]   acc;
        if (last) return blk;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gmul(coef(r, k), blk[127-32*c-8*k -: 8]);
                res[127-32*c-8*r -: 8] = acc;
            end
        end
        return res;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_accept(input logic [127:0] blk, input logic last);
        @(negedge clk);
        i_block = blk;
        i_last  = last;
        i_valid = 1'b1;
        check("accept_ready", {127'd0, o_ready}, 128'd1);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_last  = 1'b0;
    endtask

    // Edges after the current point until o_valid is seen (bounded)
    task automatic wait_out(output int k);
        k = 0;
        @(negedge clk);
        while (!o_valid && k < 12) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic run_block(input string name, input logic [127:0] blk, input logic last,
                             input logic [127:0] exp);
        int k;
        do_accept(blk, last);
        wait_out(k);
        check({name, "_lat"}, 128'(k), last ? 128'd0 : 128'd4);
        check({name, "_blk"}, o_block, exp);
        check({name, "_last"}, {127'd0, o_last}, {127'd0, last});
    endtask

    vec_t         vt[4];
    vec_t         rv;
    logic [127:0] b2b[4];
    logic [127:0] tmp;
    int           k;
    int           seen;

    initial begin
        vt[0] = '{128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0,
                  128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6};
        vt[1] = '{128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 1'b0,
                  128'h046681e5_e0cb199a_48f8d37a_2806264c};
        vt[2] = '{128'hd4d4d4d5_01010101_c6c6c6c6_d4d4d4d5, 1'b0,
                  128'hd5d5d7d6_01010101_c6c6c6c6_d5d5d7d6};
        vt[3] = '{128'h00112233_44556677_8899aabb_ccddeeff, 1'b1,
                  128'h00112233_44556677_8899aabb_ccddeeff};

        rst     = 1'b0;
        i_valid = 1'b0;
        i_block = '0;
        i_last  = 1'b0;
        i_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {127'd0, o_ready}, 128'd0);
        check("rst_valid", {127'd0, o_valid}, 128'd0);
        check("rst_block", o_block, 128'd0);
        check("rst_flags", {126'd0, o_last, o_overrun}, 128'd0);
        rst = 1'b1;
        #1;
        check("idle_ready", {127'd0, o_ready}, 128'd1);

        for (int i = 0; i < 4; i++)
            run_block($sformatf("vec%0d", i), vt[i].blk, vt[i].last, vt[i].exp);

        // Random blocks against the model, mixing last and non-last
        for (int i = 0; i < 20; i++) begin
            rv.blk  = {$urandom, $urandom, $urandom, $urandom};
            rv.last = 1'($urandom_range(0, 1));
            rv.exp  = ref_model(rv.blk, rv.last);
            run_block($sformatf("rnd%0d", i), rv.blk, rv.last, rv.exp);
        end

        // Back-to-back last blocks, one per cycle
        for (int j = 0; j < 4; j++) b2b[j] = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        i_block = b2b[0];
        i_last  = 1'b1;
        i_valid = 1'b1;
        for (int j = 1; j < 4; j++) begin
            @(negedge clk);
            check($sformatf("b2b%0d_valid", j), {127'd0, o_valid}, 128'd1);
            check($sformatf("b2b%0d_blk", j), o_block, b2b[j-1]);
            check($sformatf("b2b%0d_ready", j), {127'd0, o_ready}, 128'd1);
            i_block = b2b[j];
        end
        @(negedge clk);
        check("b2b_final_blk", o_block, b2b[3]);
        check("b2b_final_last", {127'd0, o_last}, 128'd1);
        i_valid = 1'b0;
        i_last  = 1'b0;
        @(negedge clk);
        check("b2b_drained", {127'd0, o_valid}, 128'd0);

        // Backpressure: hold in DONE, then consume and accept on the same edge
        i_ready = 1'b0;
        do_accept(vt[0].blk, 1'b0);
        wait_out(k);
        check("bp_lat", 128'(k), 128'd4);
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            check($sformatf("bp_hold%0d", j), {o_block[126:0], o_valid},
                  {vt[0].exp[126:0], 1'b1});
        end
        i_ready = 1'b1;
        i_block = vt[1].blk;
        i_last  = 1'b0;
        i_valid = 1'b1;
        #1;
        check("bp_ready", {127'd0, o_ready}, 128'd1);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        wait_out(k);
        check("bp_second_lat", 128'(k), 128'd4);
        check("bp_second_blk", o_block, vt[1].exp);

        // Overrun: offer a block while busy
        do_accept(vt[1].blk, 1'b0);
        @(negedge clk);
        check("ovr_not_ready", {127'd0, o_ready}, 128'd0);
        i_block = 128'hffffffff_00000000_ffffffff_00000000;
        i_last  = 1'b1;
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_last  = 1'b0;
        check("ovr_flag", {127'd0, o_overrun}, 128'd1);
        wait_out(k);
        check("ovr_lat", 128'(k), 128'd3);
        check("ovr_first_blk", o_block, vt[1].exp);
        check("ovr_first_last", {127'd0, o_last}, 128'd0);
        seen = 0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            if (o_valid) seen++;
        end
        check("ovr_dropped", 128'(seen), 128'd0);
        check("ovr_sticky", {127'd0, o_overrun}, 128'd1);

        // Reset while BUSY at col==2
        do_accept(vt[0].blk, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("mrst_valid", {127'd0, o_valid}, 128'd0);
        check("mrst_block", o_block, 128'd0);
        check("mrst_flags", {126'd0, o_last, o_overrun}, 128'd0);
        check("mrst_ready", {127'd0, o_ready}, 128'd0);
        rst = 1'b1;
        tmp = {32'h2d26314c, $urandom, $urandom, $urandom};
        do_accept(tmp, 1'b0);
        wait_out(k);
        check("mrst_lat", 128'(k), 128'd4);
        check("mrst_col0", {96'd0, o_block[127:96]}, {96'd0, 32'h4d7ebdf8});
        check("mrst_blk", o_block, ref_model(tmp, 1'b0));
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mix_columns.md
# mix_columns

Iterative AES MixColumns stage that consumes the ShiftRows-permuted output of the SubBytes pipeline stage and produces the round state for the AddRoundKey stage. It processes one 32-bit column per cycle, using a four-column sweep per block. The final-round bypass passes the block through unmixed. A valid/ready handshake on both sides lets the round controller stall it, and a sticky overrun flag catches upstream stages (which have no ready input) pushing data while the block is busy.

## Interface
- WORD, 32, column width in bits; only 32 supported
- NB, 4, columns per block; only 4 supported
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-low
- i_valid  input  1  i_block/i_last valid this cycle
- i_block  input  WORD*NB  state in; column c = bits [127-32c -: 32], row r of column c = bits [127-32c-8r -: 8]
- i_last  input  1  final round: bypass MixColumns
- o_ready  output  1  block will accept i_block this cycle
- o_valid  output  1  o_block/o_last valid
- o_block  output  WORD*NB  mixed state, same byte mapping as i_block
- o_last  output  1  registered copy of accepted i_last
- i_ready  input  1  downstream accepts o_block this cycle
- o_overrun  output  1  sticky: input dropped while not ready

## Operation
- States: IDLE, BUSY, DONE. Column counter col, 2 bits.
- o_ready = rst && (state==IDLE || (state==DONE && i_ready)); combinational.
- Accept = i_valid && o_ready. On accept: latch i_block into the working register, latch i_last, and clear col.
  - i_last=0: go to BUSY.
  - i_last=1: go to DONE; the block is unchanged.
- BUSY: each cycle replace column col with MixColumns(column col), then increment col. After col==3 go to DONE.
- MixColumns on column bytes a0..a3:
  - b0=2a0^3a1^a2^a3
  - b1=a0^2a1^3a2^a3
  - b2=a0^a1^2a2^3a3
  - b3=3a0^a1^a2^2a3
- GF(2^8) arithmetic: xtime(x) = {x[6:0],0} ^ (x[7] ? 8'h1b : 0); 3x = xtime(x)^x. All values are 8-bit with no carry out.
- DONE: o_valid=1; o_block and o_last are held stable until i_ready.
  - i_ready && !i_valid: go to IDLE.
  - i_ready && i_valid: simultaneous consume and accept; follow the accept rules above, with no bubble.
- Overrun: i_valid && !o_ready && rst sets o_overrun. The offered block is discarded and state is unaffected. o_overrun clears only on reset.
- i_ready while in IDLE or BUSY is ignored.

## Timing
- Reset (rst low at posedge), including mid-BUSY or mid-DONE:
  - state=IDLE, col=0
  - o_valid=0, o_block=0, o_last=0, o_overrun=0
  - any in-flight block is lost
  - o_ready=0 while rst low
- Non-last latency: accept at edge N; columns 0..3 are written at edges N+1..N+4; o_valid is high from N+4.
- Last-round latency: o_valid is high from edge N+1.
- Throughput with i_ready held high: one non-last block per 5 cycles, one last block per cycle.
- o_valid falls at the edge following i_ready, unless a new last block is accepted at that same edge.
- The output register is the working register: o_block is only meaningful while o_valid=1 and may change while in BUSY.

## Test plan
- Reset, then a single non-last block, i_ready=1:
  - input db135345_f20a225c_01010101_c6c6c6c6
  - required: o_block=8e4da1bc_9fdc589d_01010101_c6c6c6c6 exactly 4 cycles after accept; o_last=0
- FIPS-197 round 1:
  - input d4bf5d30_e0b452ae_b84111f1_1e2798e5
  - required: o_block=046681e5_e0cb199a_48f8d37a_2806264c
  - also column d4d4d4d5 -> d5d5d7d6
- i_last=1 with block 00112233_44556677_8899aabb_ccddeeff:
  - required: identical o_block one cycle after accept, o_last=1
  - back-to-back last blocks with i_ready=1 give one output per cycle
- Backpressure:
  - hold i_ready=0 for 10 cycles in DONE; o_block and o_valid must stay stable
  - raise i_ready with i_valid=1 on the same cycle; the second block is accepted with no bubble
- Overrun: assert i_valid on the cycle after a non-last accept. Required:
  - o_overrun=1 from the next cycle and held
  - first result still correct; the dropped block never appears
- Reset mid-operation:
  - rst low 1 cycle during BUSY col=2: all outputs 0, o_overrun cleared
  - next accepted block 2d26314c_... gives first column 4d7ebdf8
